// File: rtl/inst_fetch_pkg.sv
// Shared widths, FSM encoding and byte-lane helper for the byte-serial
// instruction fetch stage.
package inst_fetch_pkg;

    localparam int MEM_ADDR_W  = 32;
    localparam int STALL_W     = 6;
    localparam int INST_W      = 32;
    localparam int BYTE_W      = 8;
    localparam int IDX_W       = 2;
    localparam int STALL_IF_ID = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Little-endian placement: byte k of the word lands in bits [8k+7:8k].
    function automatic logic [INST_W-1:0] insert_byte(
        input logic [INST_W-1:0] word,
        input logic [IDX_W-1:0]  idx,
        input logic [BYTE_W-1:0] data
    );
        logic [INST_W-1:0] w_res;
        w_res = word;
        w_res[int'(idx) * BYTE_W +: BYTE_W] = data;
        return w_res;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: reads BYTES consecutive bytes from memory,
// assembles them little-endian and presents the word to IF/ID.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [MEM_ADDR_W-1:0] pc_i,
    input  logic                  br,
    input  logic [STALL_W-1:0]    stall,
    output logic                  stall_req,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [BYTE_W-1:0]     mem_data,
    output logic [INST_W-1:0]     inst_o,
    output logic [MEM_ADDR_W-1:0] pc_o,
    output logic                  inst_valid_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [MEM_ADDR_W-1:0] r_base;
    logic [MEM_ADDR_W-1:0] w_base_next;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_next;
    logic [INST_W-1:0]     r_buf;
    logic [INST_W-1:0]     w_buf_next;
    logic                  w_complete;
    logic                  w_valid_next;
    logic                  w_hold_req;

    logic [INST_W-1:0]     r_inst;
    logic [MEM_ADDR_W-1:0] r_pc;
    logic                  r_inst_valid;
    logic                  r_mem_req;
    logic [MEM_ADDR_W-1:0] r_mem_addr;
    logic                  r_stall_req;

    // Only the IF/ID stall bit matters here; the rest of the vector is dropped.
    logic w_unused_stall;
    assign w_unused_stall = ^{stall[STALL_W-1:STALL_IF_ID+1], stall[STALL_IF_ID-1:0]};
    assign w_hold_req     = stall[STALL_IF_ID];

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, fetch progress and presentation decisions; br overrides all.
    always_comb begin
        w_state_next = r_state;
        w_base_next  = r_base;
        w_idx_next   = r_idx;
        w_buf_next   = r_buf;
        w_complete   = 1'b0;
        w_valid_next = 1'b0;
        if (br) begin
            w_state_next = ST_IDLE;
            w_idx_next   = {IDX_W{1'b0}};
            w_buf_next   = {INST_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_base_next  = pc_i;
                    w_idx_next   = {IDX_W{1'b0}};
                    w_buf_next   = {INST_W{1'b0}};
                    w_state_next = ST_BUSY;
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        w_buf_next = insert_byte(r_buf, r_idx, mem_data);
                        if (r_idx == LAST_IDX) begin
                            w_complete   = 1'b1;
                            w_valid_next = 1'b1;
                            w_idx_next   = {IDX_W{1'b0}};
                            w_state_next = w_hold_req ? ST_HOLD : ST_IDLE;
                        end else begin
                            w_idx_next = r_idx + 2'd1;
                        end
                    end else begin
                        w_idx_next = r_idx;
                    end
                end
                ST_HOLD: begin
                    if (w_hold_req) begin
                        w_valid_next = 1'b1;
                        w_state_next = ST_HOLD;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Fetch base, byte index and partially assembled word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_base <= {MEM_ADDR_W{1'b0}};
            r_idx  <= {IDX_W{1'b0}};
            r_buf  <= {INST_W{1'b0}};
        end else begin
            r_base <= w_base_next;
            r_idx  <= w_idx_next;
            r_buf  <= w_buf_next;
        end
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inst       <= {INST_W{1'b0}};
            r_pc         <= {MEM_ADDR_W{1'b0}};
            r_inst_valid <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= {MEM_ADDR_W{1'b0}};
            r_stall_req  <= 1'b0;
        end else begin
            r_inst_valid <= w_valid_next;
            r_mem_req    <= (w_state_next == ST_BUSY);
            r_stall_req  <= (w_state_next != ST_IDLE);
            r_mem_addr   <= w_base_next + MEM_ADDR_W'(w_idx_next);
            if (w_complete) begin
                r_inst <= w_buf_next;
                r_pc   <= r_base;
            end else begin
                r_inst <= r_inst;
                r_pc   <= r_pc;
            end
        end
    end

    assign inst_o       = r_inst;
    assign pc_o         = r_pc;
    assign inst_valid_o = r_inst_valid;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign stall_req    = r_stall_req;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a transaction-level model predicts every
// cycle's control outputs and every fetched word; monitors compare on negedge.
module tb_inst_fetch;

    logic        clock;
    logic        reset;
    logic [31:0] pc_i;
    logic        br;
    logic [5:0]  stall;
    logic        stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_valid_o;

    inst_fetch #(.BYTES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_i        (pc_i),
        .br          (br),
        .stall       (stall),
        .stall_req   (stall_req),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .inst_valid_o(inst_valid_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: a small boot program at 0..3, address hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5 ^ {a[2:0], a[7:3]};
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    assign mem_data = mem_byte(mem_addr);

    typedef struct {
        logic        mem_req;
        logic [31:0] mem_addr;
        logic        stall_req;
        logic        valid;
        logic        zero;
    } cyc_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ins_t;

    cyc_t cyc_q[$];
    ins_t inst_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 = waiting to latch a pc, 1 = collecting bytes, 2 = holding a word.
    int          m_phase = 0;
    logic [31:0] m_base  = 32'd0;
    int          m_got   = 0;
    logic        m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and predict what the outputs show after the edge.
    task automatic step(input logic rst, input logic b, input logic [5:0] st,
                        input logic rdy, input logic [31:0] pc);
        cyc_t c;
        ins_t e;
        reset = rst; br = b; stall = st; mem_ready = rdy; pc_i = pc;
        if (rst) begin
            m_phase = 0; m_base = 32'd0; m_got = 0; m_valid = 1'b0;
        end else if (b) begin
            m_phase = 0; m_got = 0; m_valid = 1'b0;
        end else if (m_phase == 0) begin
            m_base = pc; m_got = 0; m_phase = 1; m_valid = 1'b0;
        end else if (m_phase == 1) begin
            m_valid = 1'b0;
            if (rdy) begin
                m_got++;
                if (m_got == 4) begin
                    e.pc = m_base; e.inst = mem_word(m_base);
                    inst_q.push_back(e);
                    m_valid = 1'b1; m_got = 0;
                    m_phase = st[1] ? 2 : 0;
                end
            end
        end else begin
            if (!st[1]) begin
                m_phase = 0; m_valid = 1'b0;
            end
        end
        c.mem_req   = (m_phase == 1);
        c.mem_addr  = m_base + 32'(m_got);
        c.stall_req = (m_phase != 0);
        c.valid     = m_valid;
        c.zero      = rst;
        cyc_q.push_back(c);
        @(posedge clock);
        #1;
    endtask

    logic prev_v = 1'b0;
    ins_t cur;

    // Monitor: control outputs every cycle, fetched words when presented.
    always @(negedge clock) begin
        cyc_t c;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("mem_req", 32'(mem_req), 32'(c.mem_req));
            chk("stall_req", 32'(stall_req), 32'(c.stall_req));
            chk("inst_valid_o", 32'(inst_valid_o), 32'(c.valid));
            if (c.mem_req) chk("mem_addr", mem_addr, c.mem_addr);
            if (c.zero) begin
                chk("reset_mem_addr", mem_addr, 32'd0);
                chk("reset_inst_o", inst_o, 32'd0);
                chk("reset_pc_o", pc_o, 32'd0);
            end
        end
        if (inst_valid_o && !prev_v) begin
            if (inst_q.size() == 0) begin
                chk("unexpected_inst", 32'd1, 32'd0);
            end else begin
                cur = inst_q.pop_front();
                chk("pc_o", pc_o, cur.pc);
                chk("inst_o", inst_o, cur.inst);
            end
        end else if (inst_valid_o && prev_v) begin
            chk("hold_pc_o", pc_o, cur.pc);
            chk("hold_inst_o", inst_o, cur.inst);
        end
        prev_v = inst_valid_o;
    end

    initial begin
        logic        r;
        logic        b;
        logic [5:0]  st;
        logic        rdy;
        logic [31:0] pc;
        reset = 1'b1; br = 1'b0; stall = 6'd0; mem_ready = 1'b0; pc_i = 32'd0;
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'd0);
        // Boot word 0x00100513 at address 0, memory ready every cycle.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 6'd0, 1'b1, 32'd0);
        // Wait states between bytes 1 and 2.
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 6'd0, 1'b0, 32'h40);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 6'd0, (i != 2 && i != 3), 32'h40);
        // IF/ID stalled for three cycles at completion; other stall bits noise.
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 6'd0, 1'b0, 32'h80);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'b101101, 1'b1, 32'h80);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'b000010, 1'b1, 32'h80);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 6'b111101, 1'b0, 32'h80);
        // Branch after two bytes from 0x100; next fetch from 0x200.
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 6'd0, 1'b0, 32'h100);
        step(1'b0, 1'b0, 6'd0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 6'd0, 1'b1, 32'h100);
        step(1'b0, 1'b1, 6'd0, 1'b1, 32'h200);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 6'd0, 1'b1, 32'h200);
        // Address wrap at the top of memory.
        step(1'b1, 1'b0, 6'd0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 6'd0, 1'b1, 32'hFFFFFFFE);
        // Reset while the fourth byte is returned.
        step(1'b0, 1'b0, 6'd0, 1'b0, 32'h300);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'd0, 1'b1, 32'h300);
        step(1'b1, 1'b0, 6'd0, 1'b1, 32'h300);
        step(1'b0, 1'b0, 6'd0, 1'b0, 32'h300);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            b   = ($urandom_range(0, 15) == 0);
            st  = 6'($urandom);
            st[1] = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : 32'($urandom);
            step(r, b, st, rdy, pc);
        end
        @(negedge clock);
        #1;
        chk("inst_queue_drained", 32'(inst_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL use parameter BYTES, default 4, meaning the number of bytes per fetched instruction (fixed at 4 for RV32I).
REQ-002 SHALL have port clock  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc_i  input  `MemAddrBus (32)  fetch address presented by the PC register.
REQ-005 SHALL have port br  input  1  branch/jump taken; flushes fetch in progress.
REQ-006 SHALL have port stall  input  `StallBus  pipeline stall vector; bit 1 = IF/ID stalled.
REQ-007 SHALL have port stall_req  output  1  request to stall-controller to freeze the PC stage (drives stall[0] upstream).
REQ-008 SHALL have port mem_req  output  1  byte read request to memory controller.
REQ-009 SHALL have port mem_addr  output  `MemAddrBus  byte address of current request.
REQ-010 SHALL have port mem_ready  input  1  memory controller returns mem_data for the current mem_addr this cycle.
REQ-011 SHALL have port mem_data  input  8  returned byte.
REQ-012 SHALL have port inst_o  output  32  assembled instruction to IF/ID.
REQ-013 SHALL have port pc_o  output  `MemAddrBus  address of inst_o.
REQ-014 SHALL have port inst_valid_o  output  1  inst_o/pc_o valid this cycle.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, HOLD.
REQ-016 IDLE: if !br, SHALL latch base=pc_i, set byte index idx=0, go BUSY; stall_req=0 in IDLE.
REQ-017 BUSY: SHALL drive mem_req=1, mem_addr=base+idx; stall_req=1.
REQ-018 BUSY with mem_ready=1: SHALL write mem_data into inst bits [8*idx+7:8*idx] (little-endian), idx increments.
REQ-019 BUSY with mem_ready=1 and idx==BYTES-1: SHALL register inst_o, pc_o=base, inst_valid_o=1 next cycle; go IDLE if stall[1]==0, else HOLD.
REQ-020 BUSY with mem_ready=0: SHALL hold idx, mem_addr and partial instruction unchanged.
REQ-021 HOLD: SHALL keep inst_o, pc_o, inst_valid_o=1 stable, mem_req=0, stall_req=1; go IDLE in first cycle stall[1]==0.
REQ-022 inst_valid_o SHALL be 1 for exactly one cycle per instruction when not stalled; presentation latency = 1 cycle after the 4th mem_ready.
REQ-023 br=1 in any state SHALL take priority: discard partial bytes, force inst_valid_o=0 and mem_req=0 next cycle, go IDLE; stall_req=0 next cycle.
REQ-024 br=1 coincident with mem_ready=1 SHALL discard the returned byte (no instruction emitted).
REQ-025 br=1 in IDLE SHALL suppress latching pc_i that cycle; next fetch uses pc_i of the following cycle.
REQ-026 mem_addr arithmetic SHALL be 32-bit modulo 2^32 (base 0xFFFFFFFE wraps to 0x00000000 at idx 2).
REQ-027 idx SHALL be 2 bits; never exceeds BYTES-1.
REQ-028 stall inputs other than bit 1 SHALL be ignored.

Reset
REQ-029 reset SHALL force IDLE, idx=0, base=0, inst_o=0, pc_o=0, inst_valid_o=0, mem_req=0, mem_addr=0, stall_req=0.
REQ-030 reset mid-BUSY or mid-HOLD SHALL abandon the fetch with no instruction emitted; reset dominates br.

Structure
REQ-031 FSM state encodings, BYTES and bus width macros SHALL live in the shared define.v include; no new local width literals.
REQ-032 Byte assembly SHALL be an inline shift/indexed register; no sub-module is required (a future inst_cache sits between mem_* ports and the memory controller without interface change).

Verification
REQ-033 Reset then pc_i=0x00000000, memory returns 0x13,0x05,0x10,0x00 with mem_ready every cycle -> mem_addr 0..3, inst_o=0x00100513, pc_o=0, inst_valid_o high 1 cycle.
REQ-034 mem_ready low 2 cycles between bytes 1 and 2 -> mem_addr held at base+1... base+2 unchanged, correct instruction, stall_req high throughout BUSY.
REQ-035 stall[1]=1 for 3 cycles at completion -> HOLD, inst_o/pc_o stable, inst_valid_o high 3 cycles, then IDLE.
REQ-036 br=1 after 2 bytes fetched from 0x100 -> no inst_valid_o, mem_req=0 next cycle, next fetch starts at new pc_i=0x200 from byte 0.
REQ-037 pc_i=0xFFFFFFFE -> mem_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; pc_o=0xFFFFFFFE.
REQ-038 reset asserted during BUSY byte 3 -> all outputs zero next cycle, no valid emitted.
